// File: rtl/imem_pkg.sv
// Shared sizing and state encoding for the instruction-memory boot loader.
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 256;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    CHECK,
    DONE,
    ERR
  } imem_state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot sequencer for the MIPS instruction memory: clear, stream words in from address 0, release the CPU.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailer word that must equal the modulo-2^DATA_W sum of the load.
//
// state | meaning
// IDLE  | after reset, waiting for start
// CLEAR | one-cycle clear pulse to the memory
// LOAD  | accepting words, writing one cycle after each accept
// CHECK | accepting the checksum trailer (checksum build only)
// DONE  | program loaded, CPU running
// ERR   | bad length or checksum, CPU held
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              inst_reset_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              load_memory,
  output logic [ADDR_W-1:0] mem_addr_select,
  output logic [DATA_W-1:0] instr_mem_input,
  output logic              imem_clear,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_err
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  imem_state_t       r_state;
  imem_state_t       w_next_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic w_start_acc;
  logic w_len_ok;
  logic w_last_done;
  logic w_word_ready;
  logic w_load_acc;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic              w_trailer_acc;
`endif

  always_comb begin
    w_start_acc  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    w_len_ok     = (load_len != '0) && (load_len <= LP_DEPTH);
    // count==len means the final accepted word is being written this cycle
    w_last_done  = (r_count == r_len);
    w_word_ready = (r_state == LOAD) && !w_last_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (r_state == CHECK) begin
      w_word_ready = 1'b1;
    end
    w_trailer_acc = (r_state == CHECK) && word_valid;
`endif
    w_load_acc = (r_state == LOAD) && word_valid && w_word_ready;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (w_start_acc) begin
          w_next_state = w_len_ok ? CLEAR : ERR;
        end
      end
      CLEAR: w_next_state = LOAD;
      LOAD: begin
        if (w_last_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_next_state = CHECK;
`else
          w_next_state = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_trailer_acc) begin
          w_next_state = (word_data == r_sum) ? DONE : ERR;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge inst_reset_n) begin
    if (!inst_reset_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_count   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next_state;
      r_wr_en <= w_load_acc;
      if (w_start_acc) begin
        r_len <= load_len;
      end
      if (r_state == CLEAR) begin
        r_count <= '0;
      end else if (w_load_acc) begin
        r_count <= r_count + LP_ONE;
      end
      if (w_load_acc) begin
        r_wr_addr <= r_count[ADDR_W-1:0];
        r_wr_data <= word_data;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge inst_reset_n) begin
    if (!inst_reset_n) begin
      r_sum <= '0;
    end else if (r_state == CLEAR) begin
      r_sum <= '0;
    end else if (w_load_acc) begin
      r_sum <= r_sum + word_data;
    end
  end
`endif

  assign word_ready      = w_word_ready;
  assign load_memory     = r_wr_en;
  assign mem_addr_select = r_wr_addr;
  assign instr_mem_input = r_wr_data;
  assign imem_clear      = (r_state == CLEAR);
  assign cpu_run         = (r_state == DONE);
  assign busy            = (r_state == CLEAR) || (r_state == LOAD) || (r_state == CHECK);
  assign load_err        = (r_state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random programs against a list-of-writes reference model.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int AW = IMEM_ADDR_W;
  localparam int DW = IMEM_DATA_W;
  localparam int DP = IMEM_DEPTH;

  logic          clk = 1'b0;
  logic          inst_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   load_len = '0;
  logic          word_valid = 1'b0;
  logic [DW-1:0] word_data = '0;
  logic          word_ready;
  logic          load_memory;
  logic [AW-1:0] mem_addr_select;
  logic [DW-1:0] instr_mem_input;
  logic          imem_clear;
  logic          cpu_run;
  logic          busy;
  logic          load_err;

  imem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk             (clk),
    .inst_reset_n    (inst_reset_n),
    .start           (start),
    .load_len        (load_len),
    .word_valid      (word_valid),
    .word_data       (word_data),
    .word_ready      (word_ready),
    .load_memory     (load_memory),
    .mem_addr_select (mem_addr_select),
    .instr_mem_input (instr_mem_input),
    .imem_clear      (imem_clear),
    .cpu_run         (cpu_run),
    .busy            (busy),
    .load_err        (load_err)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int            wr_cyc_q[$];
  int            clr_cnt = 0;
  int            both_cnt = 0;
  int            run_rise_cyc = -1;
  logic          run_prev = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (load_memory === 1'b1) begin
      wr_addr_q.push_back(mem_addr_select);
      wr_data_q.push_back(instr_mem_input);
      wr_cyc_q.push_back(cyc);
    end
    if (imem_clear === 1'b1) clr_cnt++;
    if (load_memory === 1'b1 && imem_clear === 1'b1) both_cnt++;
    if (cpu_run === 1'b1 && run_prev !== 1'b1) run_rise_cyc = cyc;
    run_prev = cpu_run;
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    clr_cnt = 0;
    both_cnt = 0;
    run_rise_cyc = -1;
  endtask

  task automatic test_reset();
    inst_reset_n = 1'b0;
    word_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk++;
    if ({word_ready, load_memory, imem_clear, cpu_run, busy, load_err} !== 6'b0) begin
      err++;
      $display("FAIL reset_ctrl: got %b, want 000000",
               {word_ready, load_memory, imem_clear, cpu_run, busy, load_err});
    end
    chk++;
    if (mem_addr_select !== '0 || instr_mem_input !== '0) begin
      err++;
      $display("FAIL reset_data: got addr=%h data=%h, want 0", mem_addr_select, instr_mem_input);
    end
    inst_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk++;
    if ({word_ready, load_memory, imem_clear, cpu_run, busy, load_err} !== 6'b0) begin
      err++;
      $display("FAIL idle_ctrl: got %b, want 000000 (stream word present in IDLE)",
               {word_ready, load_memory, imem_clear, cpu_run, busy, load_err});
    end
    word_valid = 1'b0;
  endtask

  // One complete load scenario: start, stream w[], optional trailer, then compare against the model.
  task automatic run_load(input string name, input logic [DW-1:0] w[$], input bit gappy,
                          input bit bad_trailer, input int ign_at);
    int            n;
    int            i;
    int            t;
    int            nw;
    int            acc_cyc[$];
    logic [DW-1:0] sum;
    bit            exp_ok;
    n = w.size();
    i = 0;
    t = 0;
    sum = '0;
    foreach (w[k]) sum = sum + w[k];
    exp_ok = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_ok = !bad_trailer;
`endif
    clear_log();
    @(negedge clk);
    start = 1'b1;
    load_len = (AW+1)'(n);
    @(negedge clk);
    start = 1'b0;
    chk++;
    if (imem_clear !== 1'b1 || cpu_run !== 1'b0 || load_err !== 1'b0 || busy !== 1'b1) begin
      err++;
      $display("FAIL %s_start: got clear=%b run=%b err=%b busy=%b, want 1 0 0 1",
               name, imem_clear, cpu_run, load_err, busy);
    end
    while (i < n && t < 4 * n + 20) begin
      @(negedge clk);
      t++;
      start = (t == ign_at);
      if (t == ign_at) load_len = 1;
      if (gappy && (t % 2 == 0)) begin
        word_valid = 1'b0;
        word_data = $urandom;
      end else begin
        word_valid = 1'b1;
        word_data = w[i];
        if (word_ready === 1'b1) begin
          acc_cyc.push_back(cyc);
          i++;
        end
      end
    end
    @(negedge clk);
    word_valid = 1'b0;
    start = 1'b0;
    chk++;
    if (i != n) begin
      err++;
      $display("FAIL %s_stream_timeout: accepted %0d, want %0d", name, i, n);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    i = 0;
    t = 0;
    while (i == 0 && t < 20) begin
      @(negedge clk);
      t++;
      word_valid = 1'b1;
      word_data = bad_trailer ? sum + 1 : sum;
      if (word_ready === 1'b1) i = 1;
    end
    @(negedge clk);
    word_valid = 1'b0;
    chk++;
    if (i == 0) begin
      err++;
      $display("FAIL %s_trailer_timeout: trailer never accepted", name);
    end
`endif
    t = 0;
    while (!(cpu_run === 1'b1 || load_err === 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    nw = wr_addr_q.size();
    chk++;
    if (nw != n) begin
      err++;
      $display("FAIL %s_wr_count: got %0d writes, want %0d", name, nw, n);
    end
    for (int k = 0; k < nw && k < n; k++) begin
      chk++;
      if (wr_addr_q[k] !== AW'(k) || wr_data_q[k] !== w[k]) begin
        err++;
        $display("FAIL %s_wr%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 name, k, wr_addr_q[k], wr_data_q[k], k, w[k]);
      end
      chk++;
      if (k < acc_cyc.size() && wr_cyc_q[k] != acc_cyc[k] + 1) begin
        err++;
        $display("FAIL %s_lat%0d: write at cycle %0d, want %0d", name, k, wr_cyc_q[k], acc_cyc[k] + 1);
      end
    end
    chk++;
    if (clr_cnt != 1 || both_cnt != 0) begin
      err++;
      $display("FAIL %s_clear: got %0d clear cycles (%0d overlapping writes), want 1 (0)",
               name, clr_cnt, both_cnt);
    end
    chk++;
    if (cpu_run !== exp_ok || load_err !== !exp_ok || busy !== 1'b0 || word_ready !== 1'b0) begin
      err++;
      $display("FAIL %s_final: got run=%b err=%b busy=%b ready=%b, want %b %b 0 0",
               name, cpu_run, load_err, busy, word_ready, exp_ok, !exp_ok);
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    if (nw > 0) begin
      chk++;
      if (run_rise_cyc != wr_cyc_q[nw-1] + 1) begin
        err++;
        $display("FAIL %s_run_timing: cpu_run rose at cycle %0d, want %0d",
                 name, run_rise_cyc, wr_cyc_q[nw-1] + 1);
      end
    end
`endif
    word_valid = 1'b1;
    word_data = $urandom;
    repeat (2) @(negedge clk);
    chk++;
    if (word_ready !== 1'b0 || wr_addr_q.size() != nw) begin
      err++;
      $display("FAIL %s_after: got ready=%b writes=%0d, want 0 and %0d",
               name, word_ready, wr_addr_q.size(), nw);
    end
    word_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [DW-1:0] w[$];
    w.push_back(32'h20080005);
    w.push_back(32'h20090003);
    w.push_back(32'h01095020);
    w.push_back(32'hAC0A0000);
    run_load("basic", w, 1'b0, 1'b0, -1);
  endtask

  task automatic test_gappy();
    logic [DW-1:0] w[$];
    repeat (3) w.push_back($urandom);
    run_load("gappy", w, 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] w[$];
    repeat (5) w.push_back($urandom);
    run_load("b2b_first", w, 1'b0, 1'b0, -1);
    w.delete();
    repeat (2) w.push_back($urandom);
    run_load("b2b_reload", w, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    logic [DW-1:0] w[$];
    repeat (6) w.push_back($urandom);
    run_load("start_ignored", w, 1'b0, 1'b0, 3);
  endtask

  task automatic test_bad_len();
    logic [AW:0] lens[3];
    lens[0] = '0;
    lens[1] = (AW+1)'(DP + 1);
    lens[2] = (AW+1)'($urandom_range(DP + 2, 2 * DP - 1));
    foreach (lens[j]) begin
      clear_log();
      @(negedge clk);
      start = 1'b1;
      load_len = lens[j];
      word_valid = 1'b1;
      word_data = $urandom;
      @(negedge clk);
      start = 1'b0;
      chk++;
      if (load_err !== 1'b1 || cpu_run !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
        err++;
        $display("FAIL bad_len%0d_state: got err=%b run=%b busy=%b ready=%b, want 1 0 0 0",
                 lens[j], load_err, cpu_run, busy, word_ready);
      end
      repeat (2) @(negedge clk);
      word_valid = 1'b0;
      chk++;
      if (clr_cnt != 0 || wr_addr_q.size() != 0 || load_err !== 1'b1) begin
        err++;
        $display("FAIL bad_len%0d_effects: got clears=%0d writes=%0d err=%b, want 0 0 1",
                 lens[j], clr_cnt, wr_addr_q.size(), load_err);
      end
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] w[$];
    repeat (DP) w.push_back($urandom);
    run_load("full", w, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [DW-1:0] w[$];
    for (int r = 0; r < 4; r++) begin
      w.delete();
      repeat ($urandom_range(1, 16)) w.push_back($urandom);
      run_load($sformatf("rand%0d", r), w, 1'($urandom_range(0, 1)), 1'b0, -1);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [DW-1:0] w[$];
    int i;
    int t;
    i = 0;
    t = 0;
    clear_log();
    @(negedge clk);
    start = 1'b1;
    load_len = 8;
    @(negedge clk);
    start = 1'b0;
    while (i < 3 && t < 40) begin
      @(negedge clk);
      t++;
      word_valid = 1'b1;
      word_data = $urandom | 32'h1;
      if (word_ready === 1'b1) i++;
    end
    @(negedge clk);
    word_valid = 1'b0;
    chk++;
    if (i != 3 || load_memory !== 1'b1 || busy !== 1'b1) begin
      err++;
      $display("FAIL midrst_pre: got accepted=%0d strobe=%b busy=%b, want 3 1 1", i, load_memory, busy);
    end
    #2 inst_reset_n = 1'b0;
    #1;
    chk++;
    if ({word_ready, load_memory, imem_clear, cpu_run, busy, load_err} !== 6'b0 ||
        mem_addr_select !== '0 || instr_mem_input !== '0) begin
      err++;
      $display("FAIL midrst_outputs: got ctrl=%b addr=%h data=%h, want all 0",
               {word_ready, load_memory, imem_clear, cpu_run, busy, load_err},
               mem_addr_select, instr_mem_input);
    end
    repeat (2) @(negedge clk);
    inst_reset_n = 1'b1;
    repeat (5) w.push_back($urandom);
    run_load("after_reset", w, 1'b0, 1'b0, -1);
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] w[$];
    w.push_back(32'd1);
    w.push_back(32'd2);
    w.push_back(32'd3);
    run_load("csum_good", w, 1'b0, 1'b0, -1);
    run_load("csum_bad", w, 1'b0, 1'b1, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gappy();
    test_back_to_back();
    test_start_ignored();
    test_bad_len();
    test_full();
    test_random();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", chk);
    $fatal(1);
  end

endmodule
